// File: rtl/arinc429_pkg.sv
// Shared types, constants and helpers for the ARINC 429 transmit path.
package arinc429_pkg;

    localparam int unsigned ARINC_WORD_W = 32;
    localparam int unsigned HS_HALF_BIT  = 120;
    localparam int unsigned LS_HALF_BIT  = 960;
    localparam int unsigned MIN_GAP_BITS = 4;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StNull,
        StGap
    } tx_state_e;

    // Bit 31 value that gives the full 32-bit word odd weight.
    function automatic logic odd_parity(input logic [ARINC_WORD_W-2:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/arinc429_bit_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module arinc429_bit_timer #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/arinc429_tx_encoder.sv
// ARINC 429 transmitter: one-word holding buffer feeding a bipolar RZ serialiser.
module arinc429_tx_encoder
    import arinc429_pkg::*;
#(
    parameter int unsigned HALF_BIT_CYCLES = HS_HALF_BIT,
    parameter int unsigned GAP_BITS        = MIN_GAP_BITS,
    parameter bit          PARITY_GEN      = 1'b1
) (
    input  logic                    Clk,
    input  logic                    Clr,
    input  logic [ARINC_WORD_W-1:0] tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic                    High,
    output logic                    Low,
    output logic                    busy,
    output logic                    tx_done
);

    localparam int unsigned GapCycles = GAP_BITS * 2 * HALF_BIT_CYCLES;
    localparam int unsigned CntW      = $clog2(GapCycles);
    localparam logic [CntW-1:0] HalfLoad = CntW'(HALF_BIT_CYCLES - 1);
    localparam logic [CntW-1:0] GapLoad  = CntW'(GapCycles - 1);

    tx_state_e               state_q;
    logic [ARINC_WORD_W-1:0] pend_data_q;
    logic                    pend_valid_q;
    logic [ARINC_WORD_W-1:0] shreg_q;
    logic [4:0]              bit_cnt_q;
    logic                    high_q, low_q, tx_done_q;

    logic                    timer_load;
    logic [CntW-1:0]         timer_val;
    logic                    timer_tc;

    arinc429_bit_timer #(
        .CNT_W(CntW)
    ) u_bit_timer (
        .clk_i     (Clk),
        .rst_ni    (Clr),
        .load_i    (timer_load),
        .load_val_i(timer_val),
        .tc_o      (timer_tc)
    );

    always_comb begin
        timer_load = 1'b0;
        timer_val  = HalfLoad;
        unique case (state_q)
            StIdle:  timer_load = pend_valid_q;
            StDrive: timer_load = timer_tc;
            StNull: begin
                timer_load = timer_tc;
                timer_val  = (bit_cnt_q == 5'd31) ? GapLoad : HalfLoad;
            end
            StGap:   timer_load = timer_tc && pend_valid_q;
        endcase
    end

    // Line outputs follow the state by one cycle, so every phase keeps its full length.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q      <= StIdle;
            pend_data_q  <= '0;
            pend_valid_q <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            high_q       <= 1'b0;
            low_q        <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            high_q    <= (state_q == StDrive) && shreg_q[0];
            low_q     <= (state_q == StDrive) && !shreg_q[0];
            tx_done_q <= (state_q == StGap) && timer_tc;

            if (tx_valid && !pend_valid_q) begin
                pend_valid_q <= 1'b1;
                pend_data_q  <= PARITY_GEN ? {odd_parity(tx_data[30:0]), tx_data[30:0]}
                                           : tx_data;
            end

            unique case (state_q)
                StIdle: begin
                    if (pend_valid_q) begin
                        shreg_q      <= pend_data_q;
                        bit_cnt_q    <= '0;
                        pend_valid_q <= 1'b0;
                        state_q      <= StDrive;
                    end
                end
                StDrive: begin
                    if (timer_tc) state_q <= StNull;
                end
                StNull: begin
                    if (timer_tc) begin
                        shreg_q <= shreg_q >> 1;
                        if (bit_cnt_q == 5'd31) begin
                            state_q <= StGap;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            state_q   <= StDrive;
                        end
                    end
                end
                StGap: begin
                    if (timer_tc) begin
                        if (pend_valid_q) begin
                            shreg_q      <= pend_data_q;
                            bit_cnt_q    <= '0;
                            pend_valid_q <= 1'b0;
                            state_q      <= StDrive;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

    assign tx_ready = ~pend_valid_q;
    assign busy     = (state_q != StIdle) || pend_valid_q;
    assign High     = high_q;
    assign Low      = low_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_arinc429_tx_encoder.sv
// Bench: default-rate encoder with parity, plus a fast encoder without parity for
// back-to-back, random and mid-word reset traffic; both compared cycle by cycle.
module tb_arinc429_tx_encoder;

    localparam int H0 = 120;
    localparam int G0 = 4 * 2 * H0;
    localparam int H1 = 3;
    localparam int G1 = 4 * 2 * H1;

    logic        clk;
    logic        clr0, clr1;
    logic [31:0] tx_data0, tx_data1;
    logic        tx_valid0, tx_valid1;
    logic        ready0, ready1, high0, high1, low0, low1, busy0, busy1, done0, done1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int excl_viol = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    int acc_cyc[$];
    bit use1 = 1'b0;

    logic mon_high, mon_low, mon_done;
    assign mon_high = use1 ? high1 : high0;
    assign mon_low  = use1 ? low1  : low0;
    assign mon_done = use1 ? done1 : done0;

    arinc429_tx_encoder u_dut0 (
        .Clk(clk), .Clr(clr0), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(ready0),
        .High(high0), .Low(low0), .busy(busy0), .tx_done(done0)
    );

    arinc429_tx_encoder #(
        .HALF_BIT_CYCLES(H1), .GAP_BITS(4), .PARITY_GEN(1'b0)
    ) u_dut1 (
        .Clk(clk), .Clr(clr1), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(ready1),
        .High(high1), .Low(low1), .busy(busy1), .tx_done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ((high0 && low0) || (high1 && low1)) excl_viol++;
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference parity: force bit 31 so the word carries an odd number of ones.
    function automatic logic [31:0] with_parity(input logic [31:0] w);
        logic [31:0] r;
        r = {1'b0, w[30:0]};
        if (($countones(r) % 2) == 0) r[31] = 1'b1;
        return r;
    endfunction

    task automatic push(input bit which, input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        if (which) begin tx_valid1 = 1'b1; tx_data1 = w; end
        else       begin tx_valid0 = 1'b1; tx_data0 = w; end
        for (int i = 0; i < 20000; i++) begin
            if ((which ? ready1 : ready0) === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) check_eq("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acc_cyc.push_back(cyc);
        if (which) tx_valid1 = 1'b0;
        else       tx_valid0 = 1'b0;
    endtask

    task automatic wait_drive(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (mon_high || mon_low) begin ok = 1'b1; break; end
        end
        if (!ok) check_eq("drive_timeout", 32'd0, 32'd1);
    endtask

    // Entered at the negedge of the word's first drive cycle; leaves at its last gap cycle.
    task automatic compare_word(input string tag, input logic [31:0] w, input int h,
                                input int g);
        int          n;
        int          mism;
        int          done_bad;
        logic [31:0] rx;
        logic [1:0]  exp_sym;
        n        = 64 * h + g;
        mism     = 0;
        done_bad = 0;
        rx       = '0;
        for (int idx = 0; idx < n; idx++) begin
            if (idx > 0) @(negedge clk);
            if (idx < 64 * h && (idx % (2 * h)) < h) exp_sym = w[idx / (2 * h)] ? 2'b10 : 2'b01;
            else                                     exp_sym = 2'b00;
            if ({mon_high, mon_low} !== exp_sym) mism++;
            if (idx < 64 * h && (idx % (2 * h)) == 0) rx[idx / (2 * h)] = mon_high;
            if (mon_done !== (idx == n - 1)) done_bad++;
        end
        check_eq({tag, "_line"}, mism, 0);
        check_eq({tag, "_rx"}, rx, w);
        check_eq({tag, "_done"}, done_bad, 0);
    endtask

    logic [31:0] words[6];
    logic [31:0] rw;

    initial begin
        clr0 = 1'b0; clr1 = 1'b0;
        tx_valid0 = 1'b0; tx_valid1 = 1'b0;
        tx_data0 = '0; tx_data1 = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_state0", {27'd0, high0, low0, busy0, done0, ready0}, 32'd1);
        check_eq("rst_state1", {27'd0, high1, low1, busy1, done1, ready1}, 32'd1);
        clr0 = 1'b1; clr1 = 1'b1;

        // Default rate with parity: all-zero word sends bit 31 as HI, 1 sends it as LO.
        use1 = 1'b0;
        push(1'b0, 32'h0000_0000);
        @(negedge clk);
        @(negedge clk);
        check_eq("lat_e1", {30'd0, high0, low0}, 32'd0);
        @(negedge clk);
        compare_word("p0", with_parity(32'h0000_0000), H0, G0);
        @(negedge clk);
        check_eq("idle_after_p0", {30'd0, busy0, done0}, 32'd0);
        push(1'b0, 32'h0000_0001);
        wait_drive(10);
        compare_word("p1", with_parity(32'h0000_0001), H0, G0);

        // Back-to-back stream on the fast encoder with valid re-presented every word.
        use1 = 1'b1;
        words[0] = 32'hA5A5_A5A5;
        words[1] = 32'h0F0F_0F0F;
        for (int k = 2; k < 6; k++) words[k] = $urandom;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        acc_cyc.delete();
        fork
            begin
                for (int k = 0; k < 6; k++) push(1'b1, words[k]);
            end
        join_none
        wait_drive(10);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            compare_word($sformatf("b2b%0d", k), words[k], H1, G1);
        end
        check_eq("b2b_accept_gap", acc_cyc[1] - acc_cyc[0], 2);
        @(negedge clk);
        check_eq("idle_after_b2b", {30'd0, busy1, ready1}, 32'd1);

        // Reset during bit 10 drive, then a fresh word from bit 0.
        rw = $urandom;
        push(1'b1, rw);
        wait_drive(10);
        repeat (10 * 2 * H1 + 1) @(negedge clk);
        #1 clr1 = 1'b0;
        #1 check_eq("async_rst", {27'd0, high1, low1, busy1, done1, ready1}, 32'd1);
        @(negedge clk);
        clr1 = 1'b1;
        rw = $urandom;
        push(1'b1, rw);
        wait_drive(10);
        compare_word("post_rst", rw, H1, G1);

        repeat (4) @(negedge clk);
        check_eq("hi_lo_excl", excl_viol, 0);
        check_eq("done_count0", done_cnt0, 2);
        check_eq("done_count1", done_cnt1, 7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arinc429_tx_encoder.md
Name: arinc429_tx_encoder

Overview:
ARINC 429 transmit encoder that sits directly upstream of the receiver module. It takes 32-bit words through a valid/ready handshake and serialises each one onto the bipolar return-to-zero line pair High/Low, which drives the receiver's High/Low inputs. It has a one-word holding buffer so back-to-back words go out with only the mandatory inter-word gap. At the default 24 MHz Clk the line rate is 100 kbps: 5 us drive phase plus 5 us null phase per bit.

Parameters:
HALF_BIT_CYCLES, 120, Clk cycles per half-bit (drive or null phase); use 960 for 12.5 kbps low speed.
GAP_BITS, 4, null bit-times inserted after every word (ARINC minimum is 4).
PARITY_GEN, 1, 1 = bit 31 is replaced by computed odd parity over bits 30:0; 0 = bit 31 is sent as supplied.

Ports:
Clk  in  1  system clock, 24 MHz nominal.
Clr  in  1  asynchronous, active-low reset.
tx_data  in  32  word to send; bit 0 is transmitted first.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  holding buffer empty; a word is accepted on a Clk edge where tx_valid && tx_ready.
High  out  1  line "HI" phase; registered.
Low  out  1  line "LO" phase; registered.
busy  out  1  state is not IDLE, or the holding buffer is full.
tx_done  out  1  one-cycle pulse at the end of the gap that follows each word.

Behaviour:
- Reset (Clr=0, asynchronous):
  - High=0, Low=0, busy=0, tx_done=0, tx_ready=1.
  - State returns to IDLE; holding buffer and shift register are cleared.
  - Reset mid-word aborts the word and drops the line to null immediately. No partial-word resume.
- Holding buffer:
  - tx_ready = ~pend_valid.
  - Acceptance sets pend_valid and stores tx_data; parity is applied at this store when PARITY_GEN=1.
  - The buffer is emptied when its word is loaded into the shift register. tx_ready rises on the cycle after that load.
  - A word can be accepted at any point during transmission.
- State machine: IDLE, DRIVE, NULL, GAP.
  - IDLE: if pend_valid, load the shift register and bit counter (0) and go to DRIVE. Latency from the acceptance edge to High/Low asserting is 2 Clk edges.
  - DRIVE for HALF_BIT_CYCLES cycles: High = current bit, Low = ~current bit. High and Low are never both 1.
  - NULL for HALF_BIT_CYCLES cycles: High = Low = 0. On exit, shift right. If bit counter = 31, go to GAP; otherwise increment and go to DRIVE.
  - GAP for GAP_BITS*2*HALF_BIT_CYCLES cycles with the line at null. On its final cycle, pulse tx_done. Then load pend if valid (go to DRIVE) or go to IDLE.
- Timing totals: one word occupies 32*2*HALF_BIT_CYCLES + GAP_BITS*2*HALF_BIT_CYCLES cycles, which is 7680 + 960 = 8640 at defaults.
- Parity: bit31 = ~^tx_data[30:0], which makes the 32-bit word have odd weight.
- Phase counter: width $clog2(GAP_BITS*2*HALF_BIT_CYCLES). It is reused across phases and reloaded on every transition; there is no wrap carry-over.
- tx_valid held high while tx_ready=0 has no effect. tx_data may change freely while it is not being accepted.

Decomposition:
- Shared package arinc429_pkg:
  - state enum (IDLE/DRIVE/NULL/GAP)
  - ARINC_WORD_W = 32
  - HS_HALF_BIT = 120, LS_HALF_BIT = 960
  - MIN_GAP_BITS = 4
  - odd_parity function
- One natural sub-module: arinc429_bit_timer, a down-counter with load value and terminal-count output, shared by the DRIVE, NULL and GAP phases.

Test Plan:
- Reset, then send 32'h0000_0001 with PARITY_GEN=0:
  - High=1 for 120 cycles starting 2 edges after acceptance, then null for 120 cycles.
  - Bits 1–31 each produce Low=1 for 120 cycles followed by 120 null.
  - tx_done pulses 8640 cycles after the first drive.
- Send 32'h0000_0000 with PARITY_GEN=1: bit 31 goes out as a High pulse (word weight 1). Send 32'h0000_0001: bit 31 goes out as a Low pulse.
- Back-to-back words A=32'hA5A5_A5A5 and B=32'h0F0F_0F0F with tx_valid held:
  - B is accepted the cycle after A's load.
  - Exactly 960 null cycles separate A's last null phase from B's first drive.
  - A receiver instance driven from High/Low outputs A then B on out_fifo.
- Assert Clr low during bit 10 of a word:
  - High=Low=0 asynchronously, tx_ready=1, busy=0.
  - After release, a new word transmits correctly from bit 0.
- Continuous check over every test: High&&Low never true; tx_ready==~pend_valid; exactly one tx_done per accepted word.
- With HALF_BIT_CYCLES=960, send 32'hFFFF_FFFF with PARITY_GEN=0: 32 High pulses of 960 cycles each, gap of 7680 cycles.
